// File: rtl/stream_frame_sink.sv
// stream_frame_sink: Avalon-ST RGB565 sink writing a linear framebuffer.
// Checks frame framing and buffers pixels against write-port stalls.
module stream_frame_sink #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              sink_ready,
    input  logic              sink_valid,
    input  logic              sink_startofpacket,
    input  logic              sink_endofpacket,
    input  logic [DATA_W-1:0] sink_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    input  logic              wr_waitrequest,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              err_sop,
    output logic              err_eop
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     DEPTH_C  = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]     ONE_C    = (PW+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(WIDTH*HEIGHT-1);

    typedef enum logic {WAIT_SOP, IN_FRAME} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pix_cnt_q;
    logic [ADDR_W-1:0]   pos;
    logic                ready_q;
    logic                accept;
    logic                push;
    logic                pop;
    logic                at_last;
    logic                empty;
    logic [PW:0]         count_q;
    logic [PW:0]         count_d;
    logic [PW-1:0]       wptr_q;
    logic [PW-1:0]       rptr_q;
    logic                mem_last_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic                frame_done_q;
    logic [15:0]         frame_count_q;
    logic                err_sop_q;
    logic                err_eop_q;

    assign accept  = sink_valid && ready_q;
    assign push    = accept && (sink_startofpacket || state_q == IN_FRAME);
    assign pos     = sink_startofpacket ? '0 : pix_cnt_q;
    assign at_last = (pos == LAST_POS);
    assign empty   = (count_q == '0);
    assign pop     = !empty && !wr_waitrequest;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_C;
        end else if (!push && pop) begin
            count_d = count_q - ONE_C;
        end
    end

    // Pixel buffer storage: {last, addr, data} per entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_last_q[i] <= 1'b0;
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (push) begin
            mem_last_q[wptr_q] <= at_last && sink_endofpacket;
            mem_addr_q[wptr_q] <= pos;
            mem_data_q[wptr_q] <= sink_data;
        end
    end

    // Framing FSM, buffer pointers and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_SOP;
            pix_cnt_q     <= '0;
            ready_q       <= 1'b0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_sop_q     <= 1'b0;
            err_eop_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            err_sop_q    <= 1'b0;
            err_eop_q    <= 1'b0;
            count_q      <= count_d;
            ready_q      <= (count_d < DEPTH_C);
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
                if (mem_last_q[rptr_q]) begin
                    frame_done_q  <= 1'b1;
                    frame_count_q <= frame_count_q + 16'd1;
                end
            end
            if (push) begin
                wptr_q    <= wptr_q + PW'(1);
                err_sop_q <= (state_q == IN_FRAME) && sink_startofpacket;
                err_eop_q <= sink_endofpacket != at_last;
                pix_cnt_q <= pos + ADDR_W'(1);
                if (sink_endofpacket || at_last) begin
                    state_q <= WAIT_SOP;
                end else begin
                    state_q <= IN_FRAME;
                end
            end
        end
    end

    assign sink_ready  = ready_q;
    assign wr_en       = !empty;
    assign wr_addr     = empty ? '0 : mem_addr_q[rptr_q];
    assign wr_data     = empty ? '0 : mem_data_q[rptr_q];
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_sop     = err_sop_q;
    assign err_eop     = err_eop_q;

endmodule

// File: tb/tb_stream_frame_sink.sv
// tb_stream_frame_sink: directed frames against a queue-based model of
// the sink, checked every cycle, plus hand-computed expectations.
module tb_stream_frame_sink;

    localparam int W = 4, H = 2, DW = 16, AW = 3, FD = 4;
    localparam int TOTAL = W * H;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sink_ready;
    logic          sink_valid = 1'b0;
    logic          sink_startofpacket = 1'b0;
    logic          sink_endofpacket = 1'b0;
    logic [DW-1:0] sink_data = '0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_waitrequest = 1'b0;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          err_sop;
    logic          err_eop;

    stream_frame_sink #(
        .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sink_ready(sink_ready),
        .sink_valid(sink_valid),
        .sink_startofpacket(sink_startofpacket),
        .sink_endofpacket(sink_endofpacket),
        .sink_data(sink_data),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_waitrequest(wr_waitrequest),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .err_sop(err_sop),
        .err_eop(err_eop)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: pending writes queue, frame position, expected pulses.
    typedef struct {
        int a;
        int d;
        bit l;
    } ent_t;

    ent_t mq[$];
    bit   m_ready, m_done, m_esop, m_eeop, m_infr;
    int   m_pos, m_fc;

    // Observation log of completed writes and pulse counts.
    int wa[$], wd[$], wc[$];
    int n_done, n_esop, n_eeop;
    bit saw_nr;
    int exp_a[$], exp_d[$];

    task automatic mreset();
        mq.delete();
        m_ready = 0; m_done = 0; m_esop = 0; m_eeop = 0;
        m_infr = 0; m_pos = 0; m_fc = 0;
    endtask

    task automatic mcompare();
        chk("sink_ready", sink_ready, m_ready);
        chk("wr_en", wr_en, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("wr_addr", wr_addr, mq[0].a);
            chk("wr_data", wr_data, mq[0].d);
        end
        chk("frame_done", frame_done, m_done);
        chk("frame_count", frame_count, m_fc);
        chk("err_sop", err_sop, m_esop);
        chk("err_eop", err_eop, m_eeop);
    endtask

    always @(negedge clock) begin
        int  pos;
        bit  acc, pop, at_end;
        cyc++;
        if (!reset_n) begin
            mreset();
            mcompare();
        end else begin
            mcompare();
            if (wr_en && !wr_waitrequest) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
                wc.push_back(cyc);
            end
            n_done += int'(frame_done);
            n_esop += int'(err_sop);
            n_eeop += int'(err_eop);
            if (sink_valid && !sink_ready) saw_nr = 1;
            // Next-cycle expectations.
            acc = sink_valid && m_ready;
            pop = (mq.size() > 0) && !wr_waitrequest;
            m_done = 0; m_esop = 0; m_eeop = 0;
            if (pop) begin
                if (mq[0].l) begin
                    m_done = 1;
                    m_fc = (m_fc + 1) % 65536;
                end
                void'(mq.pop_front());
            end
            if (acc) begin
                pos = -1;
                if (sink_startofpacket) begin
                    pos = 0;
                    m_esop = m_infr;
                end else if (m_infr) begin
                    pos = m_pos;
                end
                if (pos >= 0) begin
                    at_end = (pos == TOTAL - 1);
                    mq.push_back('{pos, int'(sink_data),
                                   at_end && sink_endofpacket});
                    m_eeop = (sink_endofpacket != at_end);
                    m_infr = !(sink_endofpacket || at_end);
                    m_pos  = pos + 1;
                end
            end
            m_ready = mq.size() < FD;
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
        n_done = 0; n_esop = 0; n_eeop = 0; saw_nr = 0;
        exp_a.delete(); exp_d.delete();
    endtask

    task automatic exp_frame(int base);
        for (int i = 0; i < TOTAL; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(base + i);
        end
    endtask

    task automatic chk_log(string name);
        int bad;
        bad = 0;
        chk({name, "_nwrites"}, wa.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
            if (wa[i] != exp_a[i] || wd[i] != exp_d[i]) bad++;
        end
        chk({name, "_order"}, bad, 0);
    endtask

    task automatic beat(bit s, bit e, int d);
        bit acc;
        int n;
        sink_valid = 1;
        sink_startofpacket = s;
        sink_endofpacket = e;
        sink_data = DW'(d);
        acc = 0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = sink_ready;
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        sink_valid = 0;
        sink_startofpacket = 0;
        sink_endofpacket = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
    endtask

    task automatic send_frame(int base);
        for (int i = 0; i < TOTAL; i++) begin
            beat(i == 0, i == TOTAL - 1, base + i);
        end
    endtask

    initial begin
        mreset();
        do_reset();

        // Clean frame, no stalls.
        clear_log();
        send_frame(1);
        idle(12);
        exp_frame(1);
        chk_log("t1");
        chk("t1_span", (wc.size() == 8) ? wc[7] - wc[0] : -1, 7);
        chk("t1_done", n_done, 1);
        chk("t1_fcount", frame_count, 1);
        chk("t1_errs", n_esop + n_eeop, 0);

        // Write stall of 10 cycles starting at pixel 2.
        do_reset();
        clear_log();
        fork
            begin
                send_frame(1);
                idle(24);
            end
            begin
                int k;
                for (k = 0; k < 60; k++) begin
                    @(posedge clock);
                    #1;
                    if (wr_en && wr_addr == 2) break;
                end
                chk("t2_stall_start", k < 60, 1);
                wr_waitrequest = 1;
                repeat (10) @(posedge clock);
                #1;
                wr_waitrequest = 0;
            end
        join
        exp_frame(1);
        chk_log("t2");
        chk("t2_ready_dropped", saw_nr, 1);
        chk("t2_fcount", frame_count, 1);

        // Junk beats before SOP are discarded.
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++) beat(0, 0, 'hAA + i);
        send_frame(1);
        idle(12);
        exp_frame(1);
        chk_log("t3");
        chk("t3_fcount", frame_count, 1);
        chk("t3_errs", n_esop + n_eeop, 0);

        // Early EOP on the 5th pixel, then a good frame.
        do_reset();
        clear_log();
        for (int i = 0; i < 5; i++) beat(i == 0, i == 4, 'h11 + i);
        idle(6);
        chk("t4_eop_pulse", n_eeop, 1);
        chk("t4_no_done", n_done, 0);
        send_frame(1);
        idle(12);
        for (int i = 0; i < 5; i++) begin
            exp_a.push_back(i);
            exp_d.push_back('h11 + i);
        end
        exp_frame(1);
        chk_log("t4");
        chk("t4_fcount", frame_count, 1);

        // SOP on the 4th pixel restarts the frame.
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++) beat(i == 0, 0, 'h21 + i);
        send_frame(1);
        idle(12);
        for (int i = 0; i < 3; i++) begin
            exp_a.push_back(i);
            exp_d.push_back('h21 + i);
        end
        exp_frame(1);
        chk_log("t5");
        chk("t5_sop_pulse", n_esop, 1);
        chk("t5_eop_pulse", n_eeop, 0);
        chk("t5_done", n_done, 1);

        // Mid-frame reset with three buffered pixels.
        clear_log();
        chk("t6_fcount_before", frame_count, 1);
        wr_waitrequest = 1;
        for (int i = 0; i < 3; i++) beat(i == 0, 0, 'h31 + i);
        idle(0);
        reset_n = 0;
        @(negedge clock);
        chk("t6_rst_wr_en", wr_en, 0);
        chk("t6_rst_ready", sink_ready, 0);
        chk("t6_rst_fcount", frame_count, 0);
        @(posedge clock);
        #1;
        reset_n = 1;
        wr_waitrequest = 0;
        idle(2);
        send_frame(1);
        idle(12);
        exp_frame(1);
        chk_log("t6");
        chk("t6_fcount", frame_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
